// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: one difference/borrow cell, LSB first, WIDTH bit-cycles per result.
// Define SERIAL_SUB_SAT_EN for unsigned saturation (diff forced to 0 when the result borrows).
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_load;
  logic             accept;
  logic             last_bit;

  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_next = {d_bit, res[WIDTH-1:1]};
  assign accept   = start && (state != S_SHIFT);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_SAT_EN
  assign diff_load = br_next ? '0 : res_next;
`else
  assign diff_load = res_next;
`endif

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= res_next;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            state  <= S_DONE;
            diff   <= diff_load;
            borrow <= br_next;
          end
        end
        // IDLE and DONE both accept a new operation; the unused encoding recovers here too
        default: begin
          if (accept) begin
            state <= S_SHIFT;
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  // {borrow, diff} from plain unsigned arithmetic
  function automatic logic [WIDTH:0] model_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic             br;
    logic [WIDTH-1:0] d;
    br = (x < y);
    d  = WIDTH'((int'(x) - int'(y) + 256) % 256);
`ifdef SERIAL_SUB_SAT_EN
    if (br) d = '0;
`endif
    return {br, d};
  endfunction

  // Launch one operation from a fresh negedge; returns cycles until done is seen (-1 on timeout)
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (diff !== 8'h00) $display("FAIL reset_diff got=%h exp=00", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL reset_borrow got=%b exp=0", borrow); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_op(8'd9, 8'd4, lat);
    checks++; if (lat !== 9) $display("FAIL basic_latency got=%0d exp=9", lat); else passed++;
    checks++; if (diff !== 8'h05) $display("FAIL basic_9m4_diff got=%h exp=05", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL basic_9m4_borrow got=%b exp=0", borrow); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done got=%b exp=0", busy); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_one_cycle got=%b exp=0", done); else passed++;
    checks++; if (diff !== 8'h05) $display("FAIL basic_diff_hold got=%h exp=05", diff); else passed++;

    run_op(8'd4, 8'd9, lat);
`ifdef SERIAL_SUB_SAT_EN
    checks++; if (diff !== 8'h00) $display("FAIL basic_4m9_diff got=%h exp=00", diff); else passed++;
`else
    checks++; if (diff !== 8'hFB) $display("FAIL basic_4m9_diff got=%h exp=fb", diff); else passed++;
`endif
    checks++; if (borrow !== 1'b1) $display("FAIL basic_4m9_borrow got=%b exp=1", borrow); else passed++;

    run_op(8'hA5, 8'hA5, lat);
    checks++; if (diff !== 8'h00) $display("FAIL basic_equal_diff got=%h exp=00", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL basic_equal_borrow got=%b exp=0", borrow); else passed++;

    run_op(8'h00, 8'h01, lat);
`ifdef SERIAL_SUB_SAT_EN
    checks++; if (diff !== 8'h00) $display("FAIL basic_0m1_diff got=%h exp=00", diff); else passed++;
`else
    checks++; if (diff !== 8'hFF) $display("FAIL basic_0m1_diff got=%h exp=ff", diff); else passed++;
`endif
    checks++; if (borrow !== 1'b1) $display("FAIL basic_0m1_borrow got=%b exp=1", borrow); else passed++;
  endtask

  task automatic test_random();
    int               lat;
    logic [WIDTH-1:0] x, y;
    logic [WIDTH:0]   exp;
    for (int i = 0; i < 24; i++) begin
      x = WIDTH'($urandom_range(0, 255));
      y = (i % 6 == 5) ? x : WIDTH'($urandom_range(0, 255));
      exp = model_sub(x, y);
      run_op(x, y, lat);
      checks++; if (lat !== WIDTH + 1) $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, lat, WIDTH + 1); else passed++;
      checks++;
      if ({borrow, diff} !== exp)
        $display("FAIL rand_result a=%h b=%h got=%b_%h exp=%b_%h", x, y, borrow, diff, exp[WIDTH], exp[WIDTH-1:0]);
      else passed++;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // Leaves the bench at the negedge where done is high so the next test can start back-to-back
  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start = 1'b1; a = 8'd20; b = 8'd3;
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk);
    lat = 2;
    start = 1'b1; a = 8'd1; b = 8'd2;
    checks++; if (busy !== 1'b1) $display("FAIL ignore_busy got=%b exp=1", busy); else passed++;
    @(negedge clk);
    start = 1'b0; lat = 3;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 9) $display("FAIL ignore_latency got=%0d exp=9", lat); else passed++;
    checks++; if (diff !== 8'h11) $display("FAIL ignore_diff got=%h exp=11", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL ignore_borrow got=%b exp=0", borrow); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int hold_err;
    start = 1'b1; a = 8'd100; b = 8'd50;
    @(negedge clk);
    start = 1'b0; lat = 1; hold_err = 0;
    while (!done && lat < 30) begin
      if (diff !== 8'h11) hold_err++;
      @(negedge clk);
      lat++;
    end
    checks++; if (hold_err !== 0) $display("FAIL b2b_diff_hold got=%0d_changes exp=0", hold_err); else passed++;
    checks++; if (lat !== 9) $display("FAIL b2b_latency got=%0d exp=9", lat); else passed++;
    checks++; if (diff !== 8'h32) $display("FAIL b2b_diff got=%h exp=32", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL b2b_borrow got=%b exp=0", borrow); else passed++;
  endtask

  task automatic test_reset_abort();
    int   lat;
    logic saw_done;
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else passed++;
    checks++; if (diff !== 8'h00) $display("FAIL abort_diff got=%h exp=00", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL abort_borrow got=%b exp=0", borrow); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", saw_done); else passed++;
    run_op(8'd7, 8'd7, lat);
    checks++; if (lat !== 9) $display("FAIL abort_fresh_latency got=%0d exp=9", lat); else passed++;
    checks++; if (diff !== 8'h00) $display("FAIL abort_fresh_diff got=%h exp=00", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL abort_fresh_borrow got=%b exp=0", borrow); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
